// File: rtl/as2650_extbus_if.sv
// Bridges the AS2650 core's single-request memory port onto a multiplexed
// external bus (AD/AH/ALE/RD_N/WR_N) with programmable wait states.
module as2650_extbus_if #(
  parameter int ADDR_W = 15,
  parameter int WAIT_W = 3
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ready,
  input  logic [WAIT_W-1:0] wait_cfg,
  output logic              busy,
  input  logic [7:0]        pad_ad_in,
  output logic [7:0]        pad_ad_out,
  output logic [7:0]        pad_ad_oeb,
  output logic [ADDR_W-9:0] pad_ah_out,
  output logic              pad_ale,
  output logic              pad_rd_n,
  output logic              pad_wr_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LATCH,
    S_ACCESS,
    S_END
  } state_t;

  state_t              state, state_nxt;
  logic [WAIT_W-1:0]   cnt, cnt_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [7:0]          wdata_q;
  logic [WAIT_W-1:0]   n_q;
  logic [7:0]          ad_out_nxt;
  logic [7:0]          oeb_nxt;
  logic [ADDR_W-9:0]   ah_nxt;

  assign busy = (state != S_IDLE);

  // Pad values are decoded from the next state so every pad output is a flop
  // that already shows the new phase in the first cycle of that phase.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    ad_out_nxt = pad_ad_out;
    oeb_nxt    = 8'hFF;
    ah_nxt     = pad_ah_out;

    unique case (state)
      S_IDLE:   if (cpu_req) state_nxt = S_ADDR;
      S_ADDR:   state_nxt = S_LATCH;
      S_LATCH: begin
        state_nxt = S_ACCESS;
        cnt_nxt   = n_q;
      end
      S_ACCESS: begin
        if (cnt == '0) state_nxt = S_END;
        else           cnt_nxt   = cnt - 1'b1;
      end
      S_END:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase

    // ADDR is only reachable from IDLE, so the live core address is used there.
    unique case (state_nxt)
      S_ADDR: begin
        oeb_nxt    = 8'h00;
        ad_out_nxt = cpu_addr[7:0];
        ah_nxt     = cpu_addr[ADDR_W-1:8];
      end
      S_LATCH:  oeb_nxt = 8'h00;
      S_ACCESS, S_END: begin
        if (we_q) begin
          oeb_nxt    = 8'h00;
          ad_out_nxt = wdata_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= S_IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      n_q        <= '0;
      pad_ad_out <= '0;
      pad_ad_oeb <= 8'hFF;
      pad_ah_out <= '0;
      pad_ale    <= 1'b0;
      pad_rd_n   <= 1'b1;
      pad_wr_n   <= 1'b1;
      cpu_rdata  <= '0;
      cpu_ready  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      if (state == S_IDLE && cpu_req) begin
        addr_q  <= cpu_addr;
        we_q    <= cpu_we;
        wdata_q <= cpu_wdata;
        n_q     <= wait_cfg;
      end
      pad_ad_out <= ad_out_nxt;
      pad_ad_oeb <= oeb_nxt;
      pad_ah_out <= ah_nxt;
      pad_ale    <= (state_nxt == S_ADDR);
      pad_rd_n   <= !(state_nxt == S_ACCESS && !we_q);
      pad_wr_n   <= !(state_nxt == S_ACCESS && we_q);
      cpu_ready  <= (state_nxt == S_END);
      // Read data is taken on the last strobe edge, while RD_N is still low.
      if (state == S_ACCESS && cnt == '0 && !we_q)
        cpu_rdata <= pad_ad_in;
    end
  end

endmodule
